// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a 3-digit multiplexed 7-segment scan bus.
// Rebuilds the hex digits shown on the display and publishes them as one coherent frame.
module seg_scan_decoder #(
  parameter logic [3:0] SETTLE         = 4'd2,
  parameter logic       SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic [6:0] seg,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic       frame_valid,
  output logic       bad_seg,
  output logic       seq_err,
  output logic       locked
);

  localparam logic STATE_SYNC   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  logic [2:0] sel_q, prevSel_q;
  logic [6:0] seg_q;
  logic       valid_q, started_q;
  logic [3:0] run_q, run_d;
  logic       captured_q, captured_d;
  logic       state_q, state_d;
  logic [1:0] expect_q, expect_d;
  logic [3:0] shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic       shBad_q, shBad_d;
  logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic       badSeg_q, badSeg_d;
  logic       frameValid_q, frameValid_d;
  logic       seqErr_q, seqErr_d;
  logic       locked_q;

  logic [6:0] segDec;
  logic [3:0] code;
  logic       patBad;
  logic       change;
  logic       capture;

  assign segDec = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

  always_comb begin
    code   = 4'h0;
    patBad = 1'b0;
    case (segDec)
      7'h3F: code = 4'h0;
      7'h06: code = 4'h1;
      7'h5B: code = 4'h2;
      7'h4F: code = 4'h3;
      7'h66: code = 4'h4;
      7'h6D: code = 4'h5;
      7'h7D: code = 4'h6;
      7'h07: code = 4'h7;
      7'h7F: code = 4'h8;
      7'h6F: code = 4'h9;
      7'h77: code = 4'hA;
      7'h7C: code = 4'hB;
      7'h39: code = 4'hC;
      7'h5E: code = 4'hD;
      7'h79: code = 4'hE;
      7'h71: code = 4'hF;
      default: patBad = 1'b1;
    endcase
  end

  // run_d counts how long sel_q has held, including the current cycle;
  // valid_q masks the cycle where sel_q still holds its reset value.
  assign change = !started_q || (sel_q != prevSel_q);

  always_comb begin
    run_d      = run_q;
    captured_d = captured_q;
    if (change) begin
      run_d      = 4'd1;
      captured_d = 1'b0;
    end else if (run_q < SETTLE) begin
      run_d = run_q + 4'd1;
    end
  end

  assign capture = valid_q && (run_d == SETTLE) && !captured_d;

  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    shBad_d      = shBad_q;
    dig0_d       = dig0_q;
    dig1_d       = dig1_q;
    dig2_d       = dig2_q;
    badSeg_d     = badSeg_q;
    frameValid_d = 1'b0;
    seqErr_d     = 1'b0;
    if (capture) begin
      if (state_q == STATE_SYNC) begin
        if (sel_q > 3'd2) begin
          seqErr_d = 1'b1;
        end else if (sel_q == 3'd0) begin
          shadow0_d = code;
          shBad_d   = patBad;
          expect_d  = 2'd1;
          state_d   = STATE_LOCKED;
        end
      end else if (sel_q == {1'b0, expect_q}) begin
        case (expect_q)
          2'd0: begin
            shadow0_d = code;
            shBad_d   = shBad_q | patBad;
            expect_d  = 2'd1;
          end
          2'd1: begin
            shadow1_d = code;
            shBad_d   = shBad_q | patBad;
            expect_d  = 2'd2;
          end
          2'd2: begin
            dig0_d       = shadow0_q;
            dig1_d       = shadow1_q;
            dig2_d       = code;
            badSeg_d     = shBad_q | patBad;
            frameValid_d = 1'b1;
            shBad_d      = 1'b0;
            expect_d     = 2'd0;
          end
          default: ;
        endcase
      end else begin
        seqErr_d  = 1'b1;
        state_d   = STATE_SYNC;
        expect_d  = 2'd0;
        shadow0_d = 4'h0;
        shadow1_d = 4'h0;
        shBad_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= 3'd0;
      seg_q        <= 7'd0;
      prevSel_q    <= 3'd0;
      valid_q      <= 1'b0;
      started_q    <= 1'b0;
      run_q        <= 4'd0;
      captured_q   <= 1'b0;
      state_q      <= STATE_SYNC;
      expect_q     <= 2'd0;
      shadow0_q    <= 4'h0;
      shadow1_q    <= 4'h0;
      shBad_q      <= 1'b0;
      dig0_q       <= 4'h0;
      dig1_q       <= 4'h0;
      dig2_q       <= 4'h0;
      badSeg_q     <= 1'b0;
      frameValid_q <= 1'b0;
      seqErr_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      sel_q        <= sel;
      seg_q        <= seg;
      prevSel_q    <= sel_q;
      valid_q      <= 1'b1;
      started_q    <= valid_q;
      run_q        <= run_d;
      captured_q   <= captured_d | capture;
      state_q      <= state_d;
      expect_q     <= expect_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      shBad_q      <= shBad_d;
      dig0_q       <= dig0_d;
      dig1_q       <= dig1_d;
      dig2_q       <= dig2_d;
      badSeg_q     <= badSeg_d;
      frameValid_q <= frameValid_d;
      seqErr_q     <= seqErr_d;
      locked_q     <= (state_d == STATE_LOCKED);
    end
  end

  assign dig0        = dig0_q;
  assign dig1        = dig1_q;
  assign dig2        = dig2_q;
  assign frame_valid = frameValid_q;
  assign bad_seg     = badSeg_q;
  assign seq_err     = seqErr_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: an active-high and an active-low instance
// see the same scan sequence and must report identical frames.
module tb_seg_scan_decoder;

  typedef struct {
    logic       isReset;
    logic [2:0] sel;
    logic [6:0] seg;
    int         len;
    int         expFv;
    int         expSe;
    logic       expLocked;
    logic [3:0] expD0;
    logic [3:0] expD1;
    logic [3:0] expD2;
    logic       expBad;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic [6:0] seg, segInv;
  logic [3:0] dig0A [0:1];
  logic [3:0] dig1A [0:1];
  logic [3:0] dig2A [0:1];
  logic       frameValidA [0:1];
  logic       badSegA [0:1];
  logic       seqErrA [0:1];
  logic       lockedA [0:1];

  int   checks = 0;
  int   passes = 0;
  vec_t vecs [$];

  assign segInv = ~seg;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(4'd2), .SEG_ACTIVE_LOW(1'b0)) dutHigh (
    .clk(clk), .rst(rst), .sel(sel), .seg(seg),
    .dig0(dig0A[0]), .dig1(dig1A[0]), .dig2(dig2A[0]),
    .frame_valid(frameValidA[0]), .bad_seg(badSegA[0]),
    .seq_err(seqErrA[0]), .locked(lockedA[0])
  );

  seg_scan_decoder #(.SETTLE(4'd2), .SEG_ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .rst(rst), .sel(sel), .seg(segInv),
    .dig0(dig0A[1]), .dig1(dig1A[1]), .dig2(dig2A[1]),
    .frame_valid(frameValidA[1]), .bad_seg(badSegA[1]),
    .seq_err(seqErrA[1]), .locked(lockedA[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic addVec(input logic isReset, input logic [2:0] s, input logic [6:0] p,
                        input int len, input int fv, input int se, input logic lk,
                        input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic bad);
    vec_t v;
    v.isReset = isReset; v.sel = s; v.seg = p; v.len = len;
    v.expFv = fv; v.expSe = se; v.expLocked = lk;
    v.expD0 = d0; v.expD1 = d1; v.expD2 = d2; v.expBad = bad;
    vecs.push_back(v);
  endtask

  function automatic int statusOf(input int d);
    return int'({lockedA[d], badSegA[d], dig0A[d], dig1A[d], dig2A[d]});
  endfunction

  // Holds one dwell (or a reset) and tallies the single-cycle pulses seen during it.
  task automatic applyStimulus(input vec_t v, input string tag);
    int fvCnt [0:1];
    int seCnt [0:1];
    int cycles;
    fvCnt[0] = 0; fvCnt[1] = 0; seCnt[0] = 0; seCnt[1] = 0;
    cycles = v.isReset ? 2 : v.len;
    if (v.isReset) rst = 1'b1;
    else begin
      sel = v.sel;
      seg = v.seg;
    end
    repeat (cycles) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (frameValidA[d]) fvCnt[d]++;
        if (seqErrA[d]) seCnt[d]++;
      end
    end
    if (v.isReset) rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d frame_valid count", tag, d), fvCnt[d], v.expFv);
      checkOutput($sformatf("%s dut%0d seq_err count", tag, d), seCnt[d], v.expSe);
      checkOutput($sformatf("%s dut%0d {locked,bad,d0,d1,d2}", tag, d), statusOf(d),
                  int'({v.expLocked, v.expBad, v.expD0, v.expD1, v.expD2}));
    end
  endtask

  initial begin
    rst = 1'b0;
    sel = 3'd0;
    seg = 7'h00;

    addVec(1, 0, 7'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    // Clean scan 0,1,2 twice: one frame per 12 cycles.
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 1, 7'h5B, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 2, 7'h4F, 4, 1, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 1, 7'h5B, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 2, 7'h4F, 4, 1, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    // Scan entering at digit 2 after reset.
    addVec(1, 0, 7'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 2, 7'h7F, 4, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 0, 7'h3F, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 1, 7'h77, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 2, 7'h71, 4, 1, 0, 1, 4'h0, 4'hA, 4'hF, 0);
    // Jump 0->2, then relock on the next digit 0.
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h0, 4'hA, 4'hF, 0);
    addVec(0, 2, 7'h4F, 4, 0, 1, 0, 4'h0, 4'hA, 4'hF, 0);
    addVec(0, 0, 7'h7D, 4, 0, 0, 1, 4'h0, 4'hA, 4'hF, 0);
    addVec(0, 1, 7'h07, 4, 0, 0, 1, 4'h0, 4'hA, 4'hF, 0);
    addVec(0, 2, 7'h6F, 4, 1, 0, 1, 4'h6, 4'h7, 4'h9, 0);
    // Undecodable digit 1, then a clean frame.
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h6, 4'h7, 4'h9, 0);
    addVec(0, 1, 7'h55, 4, 0, 0, 1, 4'h6, 4'h7, 4'h9, 0);
    addVec(0, 2, 7'h4F, 4, 1, 0, 1, 4'h1, 4'h0, 4'h3, 1);
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h1, 4'h0, 4'h3, 1);
    addVec(0, 1, 7'h5B, 4, 0, 0, 1, 4'h1, 4'h0, 4'h3, 1);
    addVec(0, 2, 7'h4F, 4, 1, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    // One-cycle dwell on digit 1 is skipped, so digit 2 arrives out of order.
    addVec(0, 0, 7'h3F, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 1, 7'h06, 1, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 2, 7'h5B, 4, 0, 1, 0, 4'h1, 4'h2, 4'h3, 0);
    // Illegal sel values in SYNC and in LOCKED.
    addVec(0, 5, 7'h3F, 4, 0, 1, 0, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 0, 7'h3F, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 6, 7'h06, 4, 0, 1, 0, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 0, 7'h3F, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 1, 7'h06, 4, 0, 0, 1, 4'h1, 4'h2, 4'h3, 0);
    addVec(0, 2, 7'h5B, 4, 1, 0, 1, 4'h0, 4'h1, 4'h2, 0);
    // Lead-in for the cycle-exact frame latency sequence below.
    addVec(1, 0, 7'h00, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 0, 7'h06, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);
    addVec(0, 1, 7'h5B, 4, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Digit-2 dwell: capture in the 2nd held cycle, frame visible after the 3rd edge only.
    sel = 3'd2;
    seg = 7'h4F;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("latency edge%0d dut%0d frame_valid", k, d),
                    int'(frameValidA[d]), (k == 3) ? 1 : 0);
        checkOutput($sformatf("latency edge%0d dut%0d dig2", k, d),
                    int'(dig2A[d]), (k >= 3) ? 3 : 0);
      end
    end

    // Asynchronous reset in the middle of the digit-1 dwell.
    sel = 3'd1;
    seg = 7'h5B;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("pre-reset dut%0d {locked,bad,d0,d1,d2}", d), statusOf(d),
                  int'({1'b1, 1'b0, 4'h1, 4'h2, 4'h3}));
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("async reset dut%0d {locked,bad,d0,d1,d2}", d), statusOf(d), 0);
      checkOutput($sformatf("async reset dut%0d {frame_valid,seq_err}", d),
                  int'({frameValidA[d], seqErrA[d]}), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
